// File: rtl/my_spi_4wire_slave.sv
// my_spi_4wire_slave: 4-wire SPI responder, oversampled in the clk domain.
// It exchanges one word per CS_N-low frame, MSB first, in any SPI mode.
// The word to send is latched when CS_N is asserted. The received word is
// delivered on rx_data together with a one-cycle valid pulse.
module my_spi_4wire_slave #(
  parameter int SPI_MODE    = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_cs_n,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic [DATA_WIDTH-1:0] spi_slave_tx_data,
  output logic                  spi_slave_tx_load,
  output logic [DATA_WIDTH-1:0] spi_slave_rx_data,
  output logic                  spi_slave_rx_data_valid,
  output logic                  spi_slave_frame_err,
  output logic                  spi_is_busy
);

  generate
    if (SPI_MODE < 0 || SPI_MODE > 3) begin : g_bad_mode
      $error("my_spi_4wire_slave: SPI_MODE must be 0..3");
    end
    if (DATA_WIDTH < 2) begin : g_bad_width
      $error("my_spi_4wire_slave: DATA_WIDTH must be at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("my_spi_4wire_slave: SYNC_STAGES must be at least 2");
    end
  endgenerate

  localparam bit CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam bit CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam int SM = SYNC_STAGES - 1;

  typedef enum logic [1:0] {
    ST_WAIT_HIGH = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync_r, sclk_sync_r, mosi_sync_r;
  logic                   cs_prev_r, sclk_prev_r;
  // Fills with ones after reset so WAIT_HIGH only trusts cs_n once the
  // synchronizer reset values have been flushed out by the real pin.
  logic [SYNC_STAGES:0]   flush_r;

  logic cs_s, sclk_s, mosi_s;
  logic cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s;
  logic lead_s, trail_s, sample_s, update_s, miso_en_s;

  state_t                 state_r, state_nxt_s;
  logic [DATA_WIDTH-1:0]  tx_shift_r, tx_shift_nxt_s;
  logic [DATA_WIDTH-1:0]  rx_shift_r, rx_shift_nxt_s;
  logic [DATA_WIDTH-1:0]  rx_data_r, rx_data_nxt_s;
  logic [CNT_W-1:0]       bit_cnt_r, bit_cnt_nxt_s;
  logic                   first_r, first_nxt_s;
  logic                   valid_r, valid_nxt_s;
  logic                   load_r, load_nxt_s;
  logic                   err_evt_r, err_evt_nxt_s;
  logic                   err_r;
  logic                   busy_r, busy_nxt_s;

  // Input synchronizers plus one extra copy of cs_n/sclk for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      sclk_sync_r <= {SYNC_STAGES{CPOL}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      cs_prev_r   <= 1'b1;
      sclk_prev_r <= CPOL;
      flush_r     <= {(SYNC_STAGES+1){1'b0}};
    end else begin
      cs_sync_r   <= {cs_sync_r[SM-1:0], spi_cs_n};
      sclk_sync_r <= {sclk_sync_r[SM-1:0], spi_sclk};
      mosi_sync_r <= {mosi_sync_r[SM-1:0], spi_mosi};
      cs_prev_r   <= cs_sync_r[SM];
      sclk_prev_r <= sclk_sync_r[SM];
      flush_r     <= {flush_r[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign cs_s        = cs_sync_r[SM];
  assign sclk_s      = sclk_sync_r[SM];
  assign mosi_s      = mosi_sync_r[SM];
  assign cs_fall_s   = cs_prev_r & ~cs_s;
  assign cs_rise_s   = ~cs_prev_r & cs_s;
  assign sclk_rise_s = ~sclk_prev_r & sclk_s;
  assign sclk_fall_s = sclk_prev_r & ~sclk_s;
  assign lead_s      = CPOL ? sclk_fall_s : sclk_rise_s;
  assign trail_s     = CPOL ? sclk_rise_s : sclk_fall_s;
  // SCLK edges only count while the frame is selected
  assign sample_s    = (CPHA ? trail_s : lead_s) & ~cs_s;
  assign update_s    = (CPHA ? lead_s : trail_s) & ~cs_s;

  // Next-state and datapath decisions for the frame FSM
  always_comb begin
    state_nxt_s    = state_r;
    tx_shift_nxt_s = tx_shift_r;
    rx_shift_nxt_s = rx_shift_r;
    rx_data_nxt_s  = rx_data_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    first_nxt_s    = first_r;
    valid_nxt_s    = 1'b0;
    load_nxt_s     = 1'b0;
    err_evt_nxt_s  = 1'b0;
    case (state_r)
      ST_WAIT_HIGH: begin
        if (flush_r[SYNC_STAGES] && cs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_HIGH;
        end
      end
      ST_IDLE: begin
        if (cs_fall_s) begin
          tx_shift_nxt_s = spi_slave_tx_data;
          rx_shift_nxt_s = {DATA_WIDTH{1'b0}};
          bit_cnt_nxt_s  = {CNT_W{1'b0}};
          first_nxt_s    = 1'b1;
          load_nxt_s     = 1'b1;
          state_nxt_s    = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // A full word wins even if CS_N rises in the same cycle
        if (bit_cnt_r == CNT_FULL) begin
          rx_data_nxt_s = rx_shift_r;
          valid_nxt_s   = 1'b1;
          state_nxt_s   = ST_DONE;
        end else if (cs_rise_s) begin
          err_evt_nxt_s = 1'b1;
          state_nxt_s   = ST_IDLE;
        end else begin
          if (sample_s) begin
            rx_shift_nxt_s = {rx_shift_r[DATA_WIDTH-2:0], mosi_s};
            bit_cnt_nxt_s  = bit_cnt_r + CNT_ONE;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r;
          end
          if (update_s) begin
            // In CPHA=1 the first leading edge only opens the frame
            if (CPHA && first_r) begin
              first_nxt_s = 1'b0;
            end else begin
              tx_shift_nxt_s = {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
            end
          end else begin
            first_nxt_s = first_r;
          end
        end
      end
      ST_DONE: begin
        if (cs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_WAIT_HIGH;
      end
    endcase
    busy_nxt_s = (state_nxt_s == ST_SHIFT) || (state_nxt_s == ST_DONE);
  end

  // FSM state, shift registers and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_WAIT_HIGH;
      tx_shift_r <= {DATA_WIDTH{1'b0}};
      rx_shift_r <= {DATA_WIDTH{1'b0}};
      rx_data_r  <= {DATA_WIDTH{1'b0}};
      bit_cnt_r  <= {CNT_W{1'b0}};
      first_r    <= 1'b0;
      valid_r    <= 1'b0;
      load_r     <= 1'b0;
      err_evt_r  <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tx_shift_r <= tx_shift_nxt_s;
      rx_shift_r <= rx_shift_nxt_s;
      rx_data_r  <= rx_data_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      first_r    <= first_nxt_s;
      valid_r    <= valid_nxt_s;
      load_r     <= load_nxt_s;
      err_evt_r  <= err_evt_nxt_s;
      err_r      <= err_evt_r;
      busy_r     <= busy_nxt_s;
    end
  end

  assign miso_en_s = ((state_r == ST_SHIFT) || (state_r == ST_DONE)) && !cs_s;
  assign spi_miso  = miso_en_s ? tx_shift_r[DATA_WIDTH-1] : 1'bz;

  assign spi_slave_tx_load       = load_r;
  assign spi_slave_rx_data       = rx_data_r;
  assign spi_slave_rx_data_valid = valid_r;
  assign spi_slave_frame_err     = err_r;
  assign spi_is_busy             = busy_r;

endmodule

// File: tb/tb_my_spi_4wire_slave.sv
// Bench for my_spi_4wire_slave: one slave per SPI mode (mode 3 is 16-bit,
// modes 0..2 are 8-bit). A bit-banged master drives each slave. Expected
// received words go through a scoreboard queue.
module tb_my_spi_4wire_slave;

  localparam int HP = 6;  // SCLK half period and Tcc, in clk cycles

  logic        clk, rst, mosi;
  logic [3:0]  cs_n, sclk;
  logic [15:0] tx_data;
  wire  [3:0]  miso, tx_load, rx_valid, frame_err, busy;
  wire  [3:0][15:0] rx_data;

  typedef struct packed {
    logic [1:0]  inst;
    logic [15:0] word;
  } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_load[4];
  int n_err[4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 3) ? 16 : 8;
    wire          miso_g;
    wire [W-1:0]  rxd;
    my_spi_4wire_slave #(.SPI_MODE(g), .DATA_WIDTH(W), .SYNC_STAGES(2)) u_dut (
      .clk                     (clk),
      .rst                     (rst),
      .spi_cs_n                (cs_n[g]),
      .spi_sclk                (sclk[g]),
      .spi_mosi                (mosi),
      .spi_miso                (miso_g),
      .spi_slave_tx_data       (tx_data[W-1:0]),
      .spi_slave_tx_load       (tx_load[g]),
      .spi_slave_rx_data       (rxd),
      .spi_slave_rx_data_valid (rx_valid[g]),
      .spi_slave_frame_err     (frame_err[g]),
      .spi_is_busy             (busy[g])
    );
    assign miso[g]    = miso_g;
    assign rx_data[g] = 16'(rxd);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop on valid pulses, plus pulse counters
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (tx_load[g]) n_load[g]++;
      if (frame_err[g]) n_err[g]++;
      if (rx_valid[g]) begin
        if (q.size() == 0) begin
          check_eq("valid_unexpected", 32'(rx_valid[g]), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_eq("rx_inst", 32'(g), 32'(e.inst));
          check_eq("rx_word", 32'(rx_data[g]), 32'(e.word));
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One master frame on slave m; called and returns on a clk falling edge
  task automatic xfer(input int m, input int w, input int ncyc, input logic [15:0] mo,
                      input int gap, input int rst_at, input bit lat_chk,
                      output logic [15:0] mi, output logic [3:0] extra, output int err_at);
    bit cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    mi = 16'h0000;
    extra = 4'h0;
    err_at = 0;
    cs_n[m] = 1'b0;
    if (!cpha) mosi = mo[w-1];
    for (int c = 1; c <= HP; c++) begin
      @(negedge clk);
      if (lat_chk && c == 2) check_eq("tx_load_early", 32'(tx_load[m]), 32'd0);
      if (lat_chk && c == 3) check_eq("tx_load_latency", 32'(tx_load[m]), 32'd1);
    end
    for (int i = 0; i < ncyc; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        wait_clk(2);
        check_eq("rst_rx_data", 32'(rx_data[m]), 32'd0);
        check_eq("rst_busy", 32'(busy[m]), 32'd0);
        check_eq("rst_valid", 32'(rx_valid[m]), 32'd0);
        check_eq("rst_err", 32'(frame_err[m]), 32'd0);
        check_eq("rst_load", 32'(tx_load[m]), 32'd0);
        rst = 1'b0;
      end
      sclk[m] = ~cpol;
      if (!cpha) begin
        if (i < w) mi[w-1-i] = miso[m];
        else if (i - w < 4) extra[i-w] = miso[m];
      end else begin
        mosi = (i < w) ? mo[w-1-i] : 1'b0;
      end
      wait_clk(HP);
      sclk[m] = cpol;
      if (!cpha) begin
        mosi = (i + 1 < w) ? mo[w-2-i] : 1'b0;
      end else begin
        if (i < w) mi[w-1-i] = miso[m];
        else if (i - w < 4) extra[i-w] = miso[m];
      end
      wait_clk(HP);
    end
    cs_n[m] = 1'b1;
    for (int c = 1; c <= gap; c++) begin
      @(negedge clk);
      if (frame_err[m] && err_at == 0) err_at = c;
    end
  endtask

  initial begin
    logic [15:0] mi;
    logic [3:0]  extra;
    int          err_at, l0, e0;
    rst = 1'b1;
    mosi = 1'b0;
    tx_data = 16'h0000;
    for (int g = 0; g < 4; g++) begin
      cs_n[g] = 1'b1;
      sclk[g] = (g >= 2);
      n_load[g] = 0;
      n_err[g] = 0;
    end
    wait_clk(3);
    rst = 1'b0;
    wait_clk(6);
    for (int g = 0; g < 4; g++) begin
      check_eq("reset_rx_data", 32'(rx_data[g]), 32'd0);
      check_eq("reset_busy", 32'(busy[g]), 32'd0);
      check_eq("reset_pulses", 32'({rx_valid[g], frame_err[g], tx_load[g]}), 32'd0);
    end

    // Mode 3, 16-bit exchange with tx_load latency check
    tx_data = 16'hA5C3;
    l0 = n_load[3];
    e0 = n_err[3];
    q.push_back('{inst: 2'd3, word: 16'h3C5A});
    xfer(3, 16, 16, 16'h3C5A, 8, -1, 1'b1, mi, extra, err_at);
    check_eq("m3_master_rx", 32'(mi), 32'hA5C3);
    check_eq("m3_load_count", 32'(n_load[3] - l0), 32'd1);
    check_eq("m3_no_err", 32'(n_err[3] - e0), 32'd0);
    check_eq("m3_busy_after", 32'(busy[3]), 32'd0);

    // Modes 0..2, 8-bit
    for (int m = 0; m < 3; m++) begin
      tx_data = 16'h007E;
      e0 = n_err[m];
      q.push_back('{inst: 2'(m), word: 16'h0081});
      xfer(m, 8, 8, 16'h0081, 8, -1, 1'b0, mi, extra, err_at);
      check_eq("m012_master_rx", 32'(mi), 32'h007E);
      check_eq("m012_no_err", 32'(n_err[m] - e0), 32'd0);
    end

    // Short frame: 5 SCLK cycles, then CS_N high
    tx_data = 16'h1234;
    e0 = n_err[3];
    xfer(3, 16, 5, 16'hFFFF, 8, -1, 1'b0, mi, extra, err_at);
    check_eq("short_err_latency", 32'(err_at), 32'd4);
    check_eq("short_err_count", 32'(n_err[3] - e0), 32'd1);
    check_eq("short_rx_kept", 32'(rx_data[3]), 32'h3C5A);
    check_eq("short_busy", 32'(busy[3]), 32'd0);

    // Extra clocks: 20 SCLK cycles in a 16-bit frame
    tx_data = 16'hC3A5;
    e0 = n_err[3];
    q.push_back('{inst: 2'd3, word: 16'h1234});
    xfer(3, 16, 20, 16'h1234, 8, -1, 1'b0, mi, extra, err_at);
    check_eq("extra_master_rx", 32'(mi), 32'hC3A5);
    check_eq("extra_miso_frozen", 32'(extra), 32'hF);
    check_eq("extra_no_err", 32'(n_err[3] - e0), 32'd0);

    // Reset mid-frame, then a clean frame
    tx_data = 16'h5555;
    e0 = n_err[3];
    xfer(3, 16, 16, 16'hFFFF, 8, 6, 1'b0, mi, extra, err_at);
    check_eq("rstmid_no_err", 32'(n_err[3] - e0), 32'd0);
    check_eq("rstmid_rx_zero", 32'(rx_data[3]), 32'd0);
    tx_data = 16'h0F0F;
    q.push_back('{inst: 2'd3, word: 16'hBEEF});
    xfer(3, 16, 16, 16'hBEEF, 8, -1, 1'b0, mi, extra, err_at);
    check_eq("after_rst_master_rx", 32'(mi), 32'h0F0F);

    // Back-to-back frames with minimum CS_N high time
    tx_data = 16'h1111;
    e0 = n_err[3];
    q.push_back('{inst: 2'd3, word: 16'hCAFE});
    xfer(3, 16, 16, 16'hCAFE, 4, -1, 1'b0, mi, extra, err_at);
    check_eq("b2b_first_rx", 32'(mi), 32'h1111);
    tx_data = 16'h2222;
    q.push_back('{inst: 2'd3, word: 16'h0401});
    xfer(3, 16, 16, 16'h0401, 8, -1, 1'b0, mi, extra, err_at);
    check_eq("b2b_second_rx", 32'(mi), 32'h2222);
    check_eq("b2b_no_err", 32'(n_err[3] - e0), 32'd0);

    wait_clk(4);
    check_eq("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/my_spi_4wire_slave.md
# my_spi_4wire_slave

Generic 4-wire SPI slave (responder), the counterpart of the team's SPI master. It oversamples the external CS_N/SCLK/MOSI lines in the local `clk` domain and shifts out a word latched at CS_N assertion on MISO. It delivers the received word with a one-cycle valid pulse. One data word is exchanged per CS_N-low frame, MSB first, in any of the four SPI modes.

## Interface
- `SPI_MODE`, 3: 0..3; CPOL = mode 2/3, CPHA = mode 1/3; any other value is an elaboration error.
- `DATA_WIDTH`, 16: bits per frame, min 2.
- `SYNC_STAGES`, 2: flip-flops in each input synchronizer, min 2.
- `clk` in 1: single block clock.
- `rst` in 1: reset, synchronous, active-high.
- `spi_cs_n` in 1: chip select from master, active low.
- `spi_sclk` in 1: serial clock from master.
- `spi_mosi` in 1: master-out slave-in.
- `spi_miso` out 1: slave-out; high-Z whenever the synchronized CS_N is high or the state is not SHIFT/DONE.
- `spi_slave_tx_data` in DATA_WIDTH: word to transmit; sampled on CS_N assertion.
- `spi_slave_tx_load` out 1: one-cycle pulse in the cycle tx_data is latched.
- `spi_slave_rx_data` out DATA_WIDTH: last complete received word; first received bit lands in the MSB.
- `spi_slave_rx_data_valid` out 1: one-cycle pulse when rx_data updates.
- `spi_slave_frame_err` out 1: one-cycle pulse when CS_N deasserts before DATA_WIDTH bits have been sampled.
- `spi_is_busy` out 1: high in SHIFT and DONE.

## Operation
- **Synchronizers:** cs_n, sclk and mosi each pass through a SYNC_STAGES flop chain. Edge detection compares the last stage against one extra registered copy.
- **Edge definitions:**
  - Leading edge = rising if CPOL=0, falling if CPOL=1. Trailing edge is the opposite.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1.
  - Update edge = trailing if CPHA=0, leading if CPHA=1. For CPHA=1, the first leading edge of a frame does not shift.
- **States:** WAIT_HIGH, IDLE, SHIFT, DONE.
  - WAIT_HIGH: entered on reset. Moves to IDLE once synced cs_n = 1. A frame already in progress at reset release is therefore never joined.
  - IDLE: on cs_n fall, latch tx_data into the tx shift register, pulse tx_load, clear the bit counter and rx shift register, and go to SHIFT. MISO drives tx_shift MSB.
  - SHIFT:
    - On a sample edge, rx_shift <= {rx_shift[W-2:0], mosi_sync} and the bit counter increments.
    - On an update edge, tx_shift <<= 1.
    - When the counter reaches DATA_WIDTH, copy rx_shift (including the final bit) to rx_data, pulse rx_data_valid, and go to DONE.
    - On cs_n rise, pulse frame_err, leave rx_data unchanged, and go to IDLE.
  - DONE: all SCLK edges are ignored and tx_shift is frozen. On cs_n rise, go to IDLE with no pulse.
- **Event priority:** cs_n rise beats any SCLK edge in the same cycle. A sample edge coincident with cs_n rise is discarded.
- **Unframed edges:** SCLK edges while cs_n is high are ignored in every state.
- **Counter widths:** bit counter is $clog2(DATA_WIDTH+1) bits and never wraps; it saturates at DATA_WIDTH via the transition to DONE.

## Timing
- **Reset values:** rx_data = 0; rx_data_valid, frame_err, tx_load, is_busy = 0; miso = Z; state = WAIT_HIGH; synchronizer flops = 1 for cs_n, CPOL for sclk, 0 for mosi.
- **CS_N assertion:** the CS_N pin fall produces tx_load and a driven MISO SYNC_STAGES+1 clk cycles later (3 for the default).
- **SCLK edges:** a pin edge is acted on SYNC_STAGES+1 cycles after it occurs. MISO changes on the following clk edge.
- **rx_data_valid:** pulses SYNC_STAGES+2 cycles after the last sample edge on the pin.
- **frame_err:** pulses SYNC_STAGES+2 cycles after the CS_N pin rise.
- **Master constraints** (required; the slave does not check them):
  - SCLK half-period ≥ (SYNC_STAGES+3) clk periods.
  - CS_N-to-first-edge (Tcc) ≥ (SYNC_STAGES+3) clk periods.
  - CS_N high time ≥ (SYNC_STAGES+2) clk periods.
  - Example: with a 100 MHz clk, a 4 MHz SCLK and the master's 500 ns Tcc both satisfy these.

## Test plan
- **Mode 3, 16-bit:** master sends 0x3C5A; tx_data = 0xA5C3 → one rx_data_valid pulse with rx_data = 0x3C5A; master receives 0xA5C3; tx_load pulses exactly once.
- **Modes 0, 1, 2 (DATA_WIDTH=8):** master sends 0x81 while tx_data = 0x7E in each mode → rx_data = 0x81, master reads 0x7E, no frame_err.
- **Short frame:** mode 3, 5 SCLK cycles, then CS_N high → frame_err pulses once, no rx_data_valid, rx_data retains its prior value, state returns to IDLE.
- **Extra clocks:** 20 SCLK cycles in a 16-bit frame → a single valid pulse with the first 16 bits; MISO holds the frozen tx_shift MSB during the extra clocks; no error on CS_N rise.
- **Reset mid-frame:** assert rst for 2 cycles while CS_N is low mid-frame → all outputs at reset values; no valid or err for the rest of that frame; the next complete frame is received correctly.
- **Back-to-back frames:** minimum CS_N high time, tx_data changed 0x1111 → 0x2222 between frames → master reads 0x1111 then 0x2222; two valid pulses with the correct rx words.
